// File: rtl/sample_framer.sv
// Ping-pong frame buffer: collects FRAME_LEN samples into one bank while the
// other bank streams out over a valid/ready handshake.
//   state       | meaning
//   W_FILL      | writing incoming samples at wptr
//   W_FULL_WAIT | write bank full, read bank busy; strobes are dropped
//   R_IDLE      | no frame pending downstream
//   R_STREAM    | presenting the read bank, one sample per handshake
module sample_framer #(
  parameter int DATA_BITS = 24,
  parameter int FRAME_LEN = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_BITS-1:0]         in_data,
  input  logic                         in_valid,
  output logic [DATA_BITS-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(FRAME_LEN)-1:0] out_index,
  output logic                         out_last,
  output logic                         overflow,
  input  logic                         clear_ovf,
  output logic [15:0]                  drop_count
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = '0;

  typedef enum logic {W_FILL = 1'b0, W_FULL_WAIT = 1'b1} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_STREAM = 1'b1} rstate_e;

  wstate_e              wstate_q, wstate_d;
  rstate_e              rstate_q, rstate_d;
  logic [IDX_W-1:0]     wptr_q, wptr_d;
  logic                 wbank_q, wbank_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]     out_index_q, out_index_d;
  logic                 out_last_q, out_last_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_count_q, drop_count_d;

  logic [DATA_BITS-1:0] mem [2*FRAME_LEN];
  logic                 mem_we;
  logic [IDX_W:0]       mem_waddr;
  logic [IDX_W:0]       mem_raddr;
  logic [DATA_BITS-1:0] rd_data;

  logic             handshake;
  logic             read_free;
  logic             frame_done;
  logic             swap;
  logic             drop;
  logic [IDX_W-1:0] nxt_idx;

  assign handshake  = out_valid_q & out_ready;
  assign read_free  = (rstate_q == R_IDLE) || (handshake && out_last_q);
  assign frame_done = (wstate_q == W_FILL) && in_valid && (wptr_q == LAST_IDX);
  assign swap       = read_free && (frame_done || (wstate_q == W_FULL_WAIT));
  assign drop       = (wstate_q == W_FULL_WAIT) && in_valid && !read_free;
  assign nxt_idx    = out_index_q + IDX_W'(1);

  // On a swap the old write bank becomes the read bank, so prefetch its index 0.
  assign mem_raddr = swap ? {wbank_q, ZERO_IDX} : {~wbank_q, nxt_idx};
  assign rd_data   = mem[mem_raddr];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_data;
  end

  always_comb begin
    wstate_d     = wstate_q;
    rstate_d     = rstate_q;
    wptr_d       = wptr_q;
    wbank_d      = wbank_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    out_last_d   = out_last_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    mem_we       = 1'b0;
    mem_waddr    = {wbank_q, wptr_q};

    case (wstate_q)
      W_FILL: begin
        if (in_valid) begin
          mem_we = 1'b1;
          if (wptr_q == LAST_IDX) begin
            wptr_d = ZERO_IDX;
            if (!swap) wstate_d = W_FULL_WAIT;
          end else begin
            wptr_d = wptr_q + IDX_W'(1);
          end
        end
      end
      W_FULL_WAIT: begin
        if (read_free) begin
          wstate_d = W_FILL;
          wptr_d   = ZERO_IDX;
          // A strobe landing on the swap goes to index 0 of the fresh bank.
          if (in_valid) begin
            mem_we    = 1'b1;
            mem_waddr = {~wbank_q, ZERO_IDX};
            wptr_d    = IDX_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (swap) begin
      wbank_d     = ~wbank_q;
      rstate_d    = R_STREAM;
      out_valid_d = 1'b1;
      out_data_d  = rd_data;
      out_index_d = ZERO_IDX;
      out_last_d  = 1'b0;
    end else if (handshake) begin
      if (out_last_q) begin
        rstate_d    = R_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        out_data_d  = rd_data;
        out_index_d = nxt_idx;
        out_last_d  = (nxt_idx == LAST_IDX);
      end
    end

    if (clear_ovf) begin
      overflow_d   = 1'b0;
      drop_count_d = 16'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q     <= W_FILL;
      rstate_q     <= R_IDLE;
      wptr_q       <= ZERO_IDX;
      wbank_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= ZERO_IDX;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      wstate_q     <= wstate_d;
      rstate_q     <= rstate_d;
      wptr_q       <= wptr_d;
      wbank_q      <= wbank_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      out_last_q   <= out_last_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer with FRAME_LEN = 8, DATA_BITS = 24.
module tb_sample_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic        in_valid;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_index;
  logic        out_last;
  logic        overflow;
  logic        clear_ovf;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [2:0] exp_idx = 3'd0;

  sample_framer #(.DATA_BITS(24), .FRAME_LEN(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .overflow(overflow),
    .clear_ovf(clear_ovf), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_sample(input logic [23:0] v);
    exp_t e;
    e.data = v;
    e.idx  = exp_idx;
    e.last = (exp_idx == 3'd7);
    exp_q.push_back(e);
    exp_idx = exp_idx + 3'd1;
  endtask

  // One-cycle strobe; keep=0 marks a sample the design is expected to drop or lose.
  task automatic send(input logic [23:0] v, input bit keep);
    in_valid = 1'b1;
    in_data  = v;
    if (keep) expect_sample(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 2) begin
      tick();
      n++;
    end
    check(name, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < limit) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic monitor_step();
    if (!rst && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got data=%h idx=%0d expected no output", out_data, out_index);
      end else begin
        mon_e = exp_q[0];
        if (out_data !== mon_e.data || out_index !== mon_e.idx || out_last !== mon_e.last) begin
          errors++;
          $display("FAIL out_sample got data=%h idx=%0d last=%0b expected data=%h idx=%0d last=%0b",
                   out_data, out_index, out_last, mon_e.data, mon_e.idx, mon_e.last);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_ovf = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    repeat (3) tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_index", {29'd0, out_index}, 32'd0);
    check("rst_out_data", {8'd0, out_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_count", {16'd0, drop_count}, 32'd0);
    rst = 1'b0;
    tick();

    // Single frame, ready held high.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(24'(i), 1'b1);
    wait_valid("single_latency");
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("single_burst_cycles", n, 32'd8);
    check("single_valid_after_last", {31'd0, out_valid}, 32'd0);

    // Backpressure with ready pattern 1,0,0,1.
    out_ready = 1'b0;
    for (int i = 101; i <= 108; i++) send(24'(i), 1'b1);
    wait_valid("bp_latency");
    for (int c = 0; c < 64 && (exp_q.size() != 0 || out_valid); c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    check("bp_drained", exp_q.size(), 32'd0);

    // Overflow: 20 strobes with downstream stalled, last 4 dropped.
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) send(24'(i), i <= 16);
    tick();
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_drop_count", {16'd0, drop_count}, 32'd4);
    check("ovf_pending_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drain("ovf_drained", 40);
    check("ovf_sticky_count", {16'd0, drop_count}, 32'd4);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("clr_overflow", {31'd0, overflow}, 32'd0);
    check("clr_drop_count", {16'd0, drop_count}, 32'd0);

    // Strobe coinciding with last handshake while in FULL_WAIT.
    out_ready = 1'b0;
    for (int i = 201; i <= 208; i++) send(24'(i), 1'b1);
    for (int i = 211; i <= 218; i++) send(24'(i), 1'b1);
    out_ready = 1'b1;
    repeat (7) tick();
    send(24'd221, 1'b1);
    check("sim_drop_count", {16'd0, drop_count}, 32'd0);
    check("sim_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 222; i <= 228; i++) send(24'(i), 1'b1);
    drain("sim_drained", 40);
    check("sim_drop_count_end", {16'd0, drop_count}, 32'd0);

    // Reset mid-stream with a partial frame in the write bank.
    out_ready = 1'b0;
    for (int i = 301; i <= 308; i++) send(24'(i), 1'b1);
    out_ready = 1'b1;
    send(24'd901, 1'b0);
    send(24'd902, 1'b0);
    send(24'd903, 1'b0);
    check("pre_rst_remaining", exp_q.size(), 32'd5);
    rst = 1'b1;
    out_ready = 1'b0;
    exp_q.delete();
    exp_idx = 3'd0;
    tick();
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_index", {29'd0, out_index}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(24'hAAAAAA + 24'(i), 1'b1);
    wait_valid("post_rst_latency");
    drain("post_rst_drained", 40);
    check("post_rst_drop_count", {16'd0, drop_count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 24, giving the sample width in bits.
REQ-002 The block SHALL have parameter FRAME_LEN, default 256, giving samples per frame; it SHALL be a power of two in the range 4..4096.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_data, input, DATA_BITS bits: signed sample from the I2S receiver.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a one-cycle strobe qualifying in_data.
REQ-007 The block SHALL have port out_data, output, DATA_BITS bits: frame sample to the FFT.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-010 The block SHALL have port out_index, output, log2(FRAME_LEN) bits: position of out_data within the frame.
REQ-011 The block SHALL have port out_last, output, 1 bit: high with out_valid when out_index equals FRAME_LEN-1.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a sample is dropped.
REQ-013 The block SHALL have port clear_ovf, input, 1 bit: when high, clears overflow and drop_count.
REQ-014 The block SHALL have port drop_count, output, 16 bits: count of dropped samples, saturating.

Function
REQ-015 Storage SHALL be two banks of FRAME_LEN x DATA_BITS, used ping-pong: one write bank and one read bank.
REQ-016 The write side SHALL have two states: FILL and FULL_WAIT.
REQ-017 The read side SHALL have two states: IDLE and STREAM.
REQ-018 In FILL, each in_valid SHALL write in_data to the write bank at wptr, then increment wptr.
REQ-019 A write at wptr = FRAME_LEN-1 SHALL complete the frame.
REQ-020 On frame completion with the read side IDLE, the same cycle SHALL perform a swap: toggle the bank select, set wptr to 0, keep the write side in FILL, and move the read side to STREAM at index 0.
REQ-021 On frame completion with the read side in STREAM, the write side SHALL enter FULL_WAIT.
REQ-022 In FULL_WAIT, each in_valid SHALL be dropped: no write, overflow set to 1, drop_count incremented, saturating at 65535.
REQ-023 In FULL_WAIT, the swap SHALL occur on the cycle in which the read side is IDLE or completes its last handshake; the write side then returns to FILL with wptr = 0.
REQ-024 If in_valid coincides with that swap cycle, the sample SHALL be written to the new write bank at index 0 and SHALL NOT be dropped.
REQ-025 The read side SHALL use a valid/ready handshake: a transfer occurs on a cycle with out_valid and out_ready both high.
REQ-026 While out_valid is high and out_ready is low, out_data, out_index and out_last SHALL hold stable.
REQ-027 In STREAM, out_valid SHALL first rise no later than 2 cycles after the swap.
REQ-028 With out_ready held high, the read side SHALL deliver one sample per cycle with no bubbles until the last sample.
REQ-029 Samples SHALL be delivered in write order, index 0 to FRAME_LEN-1, bit-exact with no arithmetic applied.
REQ-030 The handshake on out_last SHALL return the read side to IDLE, with out_valid low on the following cycle unless a swap occurs in that handshake cycle.
REQ-031 The write and read sides SHALL never address the same bank while the read side is in STREAM.
REQ-032 clear_ovf SHALL take precedence over a drop in the same cycle: the result is overflow = 0 and drop_count = 0.
REQ-033 Pointer wrap from FRAME_LEN-1 SHALL go to 0; the pointer SHALL never reach an out-of-range index.

Reset
REQ-034 While rst is high, the write side SHALL be in FILL with wptr = 0 and the write bank = 0.
REQ-035 While rst is high, the read side SHALL be IDLE, and out_valid, out_last, out_index, out_data, overflow and drop_count SHALL all be 0.
REQ-036 Reset mid-frame or mid-stream SHALL abandon all partial data; the first in_valid after rst falls SHALL be stored at index 0.
REQ-037 Memory contents SHALL NOT require reset.

Verification (FRAME_LEN = 8, DATA_BITS = 24)
REQ-038 Single frame: 8 strobes of values 1..8 with out_ready held 1 -> out_valid rises no later than 2 cycles after the 8th strobe, then outputs 1..8 on consecutive cycles with out_index 0..7 and out_last only on value 8.
REQ-039 Backpressure: out_ready toggles 1,0,0,1 repeatedly -> same sequence, with each value held stable while out_ready is 0 and no value lost or duplicated.
REQ-040 Overflow: out_ready = 0, send 20 strobes -> frame A (1..8) is pending, frame B (9..16) is held in FULL_WAIT, 4 samples are dropped, overflow = 1 and drop_count = 4; then out_ready = 1 -> outputs are 1..16; then clear_ovf pulse -> overflow = 0 and drop_count = 0.
REQ-041 Simultaneous events: in_valid in the same cycle as the last handshake of the pending read while in FULL_WAIT -> that sample appears as out_index 0 of the frame after next, and drop_count is unchanged.
REQ-042 Reset mid-stream: assert rst after 3 outputs -> out_valid = 0 on the next cycle; after release, 8 new strobes (0xAAAAAA..) -> a clean frame starting at index 0 is delivered.
